// File: rtl/wb_sram_banked_ctrl.sv
// Wishbone B4 slave over NUM_BANKS single-port SRAM macros with zero-wait bursts.
// Optional idle power-down of the macros is enabled with `define SRAM_SLEEP_EN.
module wb_sram_banked_ctrl #(
  parameter int BANK_AW     = 13,
  parameter int NUM_BANKS   = 2,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    cyc_i,
  input  logic                                    stb_i,
  input  logic                                    we_i,
  input  logic [BANK_AW+$clog2(NUM_BANKS)+1:2]    adr_i,
  input  logic [3:0]                              sel_i,
  input  logic [31:0]                             dat_i,
  input  logic [2:0]                              cti_i,
  input  logic [1:0]                              bte_i,
  output logic [31:0]                             dat_o,
  output logic                                    ack_o,
  output logic [BANK_AW-1:0]                      mem_adr_o,
  output logic [31:0]                             mem_d_o,
  output logic [31:0]                             mem_wem_o,
  output logic [NUM_BANKS-1:0]                    mem_we_o,
  output logic [NUM_BANKS-1:0]                    mem_oe_o,
  output logic [NUM_BANKS-1:0]                    mem_me_o,
  input  logic [32*NUM_BANKS-1:0]                 mem_q_i,
  output logic [3:0]                              mem_rm_o
);
  localparam int BW  = $clog2(NUM_BANKS);
  localparam int AW  = BANK_AW + BW;
  localparam int BWI = (BW == 0) ? 1 : BW;

  if (NUM_BANKS < 1 || NUM_BANKS > 8 || (1 << BW) != NUM_BANKS) begin : g_chk_banks
    $error("NUM_BANKS must be a power of two in 1..8");
  end
  if (IDLE_CYCLES < 2) begin : g_chk_idle
    $error("IDLE_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACT   = 2'd1
`ifdef SRAM_SLEEP_EN
    , S_SLEEP = 2'd2,
    S_WAKE  = 2'd3
`endif
  } state_t;

  state_t           r_state, w_state_n;
  logic [AW-1:0]    r_cur;
  logic [BWI-1:0]   r_bsel;
  logic             r_we;
  logic [AW-1:0]    w_adr, w_mask, w_next;
  logic             w_req, w_burst, w_ack;

  function automatic logic [BWI-1:0] bank_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> BANK_AW;
    return s[BWI-1:0];
  endfunction

  function automatic logic [NUM_BANKS-1:0] dec(input logic [BWI-1:0] b);
    return NUM_BANKS'(1) << b;
  endfunction

  assign w_adr   = adr_i;
  assign w_req   = cyc_i & stb_i;
  assign w_burst = (cti_i == 3'b010);

  // Only the masked low bits advance; wrap bursts keep the upper bits fixed.
  always_comb begin
    case (bte_i)
      2'b01:   w_mask = AW'(3);
      2'b10:   w_mask = AW'(7);
      2'b11:   w_mask = AW'(15);
      default: w_mask = '1;
    endcase
  end
  assign w_next = (r_cur & ~w_mask) | ((r_cur + AW'(1)) & w_mask);

`ifdef SRAM_SLEEP_EN
  localparam int IW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  logic [IW-1:0] r_idle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_idle <= '0;
    else if (r_state == S_IDLE && !w_req && r_idle != IDLE_LAST)
      r_idle <= r_idle + IW'(1);
    else
      r_idle <= '0;
  end

  assign mem_me_o = (r_state == S_SLEEP) ? '0 : '1;
`else
  assign mem_me_o = {NUM_BANKS{~rst_i}};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_state_n = S_ACT;
`ifdef SRAM_SLEEP_EN
        else if (r_idle == IDLE_LAST) w_state_n = S_SLEEP;
`endif
      end
      S_ACT: begin
        w_ack = w_req;
        if (!(w_req && w_burst)) w_state_n = S_IDLE;
      end
`ifdef SRAM_SLEEP_EN
      S_SLEEP: if (w_req) w_state_n = S_WAKE;
      S_WAKE:  w_state_n = S_IDLE;
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur  <= '0;
      r_bsel <= '0;
      r_we   <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_cur  <= w_adr;
      r_bsel <= bank_of(w_adr);
      r_we   <= we_i;
    end else if (w_ack && w_burst) begin
      r_cur  <= w_next;
      r_bsel <= bank_of(w_next);
    end
  end

  // Reads prefetch the following beat; writes address the beat being acked.
  always_comb begin
    mem_adr_o = r_cur[BANK_AW-1:0];
    mem_we_o  = '0;
    mem_oe_o  = '0;
    case (r_state)
      S_IDLE: begin
        mem_adr_o = w_adr[BANK_AW-1:0];
        if (w_req && !rst_i) mem_oe_o = dec(bank_of(w_adr));
      end
      S_ACT: begin
        if (r_we) begin
          if (w_ack) mem_we_o = dec(r_bsel);
        end else begin
          mem_adr_o = w_next[BANK_AW-1:0];
          mem_oe_o  = dec(bank_of(w_next));
        end
      end
      default: ;
    endcase
  end

  assign ack_o     = w_ack;
  assign dat_o     = mem_q_i[32*r_bsel +: 32];
  assign mem_d_o   = dat_i;
  assign mem_wem_o = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign mem_rm_o  = 4'b1000;
endmodule

// File: tb/tb_wb_sram_banked_ctrl.sv
// Scoreboard bench for wb_sram_banked_ctrl: 2 banks of 16 words behind a behavioural SRAM.
module tb_wb_sram_banked_ctrl;
  logic        clk = 1'b0;
  logic        rst_i, cyc, stb, we;
  logic [6:2]  adr;
  logic [3:0]  sel;
  logic [31:0] dat, dat_o;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack_o;
  logic [3:0]  mem_adr_o;
  logic [31:0] mem_d_o, mem_wem_o;
  logic [1:0]  mem_we_o, mem_oe_o, mem_me_o;
  logic [63:0] mem_q_i;
  logic [3:0]  mem_rm_o;

  typedef struct {
    bit          rd;
    bit          last;
    logic [31:0] d;
    logic [4:0]  a;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] rmem [0:31];
  logic [31:0] sram [0:1][0:15];
  logic [31:0] q [0:1];

  always #5 clk = ~clk;

  wb_sram_banked_ctrl #(.BANK_AW(4), .NUM_BANKS(2), .IDLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .cti_i(cti), .bte_i(bte), .dat_o(dat_o), .ack_o(ack_o),
    .mem_adr_o(mem_adr_o), .mem_d_o(mem_d_o), .mem_wem_o(mem_wem_o),
    .mem_we_o(mem_we_o), .mem_oe_o(mem_oe_o), .mem_me_o(mem_me_o),
    .mem_q_i(mem_q_i), .mem_rm_o(mem_rm_o));

  // Behavioural macros: 1-cycle read latency, Q holds between reads.
  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++) sram[b][r] = 32'h1000_0000 * (b + 1) + r;
    for (int w = 0; w < 32; w++) rmem[w] = 32'h1000_0000 * ((w >> 4) + 1) + (w & 15);
    q[0] = 32'h1111_1111;
    q[1] = 32'h2222_2222;
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_me_o[b] && mem_we_o[b])
        sram[b][mem_adr_o] <= (sram[b][mem_adr_o] & ~mem_wem_o) | (mem_d_o & mem_wem_o);
      if (mem_me_o[b] && mem_oe_o[b]) q[b] <= sram[b][mem_adr_o];
    end
  end
  assign mem_q_i = {q[1], q[0]};

  // Monitor: every ack pops one expected beat.
  initial begin
    exp_t e;
    bit   prev_ack, prev_last;
    prev_ack = 0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (ack_o === 1'b1 && !rst_i) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack got=ack exp=none");
        end else begin
          e = sbq.pop_front();
          if (e.rd && dat_o !== e.d) begin
            bad++;
            $display("FAIL rd_data adr=%0d got=%h exp=%h", e.a, dat_o, e.d);
          end else if (!e.rd && (mem_we_o !== (2'b01 << e.a[4]) || mem_adr_o !== e.a[3:0])) begin
            bad++;
            $display("FAIL wr_strobe adr=%0d got we=%b row=%0d exp we=%b row=%0d",
                     e.a, mem_we_o, mem_adr_o, 2'b01 << e.a[4], e.a[3:0]);
          end
          if (prev_ack && prev_last) begin
            total++; bad++;
            $display("FAIL ack_after_last got=ack exp=idle_cycle");
          end
          prev_last = e.last;
        end
      end
      prev_ack = (ack_o === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] nxt(input logic [4:0] a, input logic [1:0] bt);
    logic [4:0] m;
    case (bt)
      2'b01:   m = 5'h03;
      2'b10:   m = 5'h07;
      2'b11:   m = 5'h0F;
      default: m = 5'h1F;
    endcase
    return (a & ~m) | ((a + 5'd1) & m);
  endfunction

  task automatic wait_ack(input int exp, output bit ok);
    int lat;
    lat = 0; ok = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack_o === 1'b1) begin ok = 1; break; end
    end
    total++;
    if (!ok || lat != exp) begin
      bad++;
      $display("FAIL ack_latency got=%0d exp=%0d", lat, exp);
    end
  endtask

  // n beats, dropping stb after 'stop' beats when stop < n.
  task automatic xfer(input bit wr, input logic [4:0] a0, input logic [1:0] bt, input int n,
                      input int stop, input logic [3:0] sl, input logic [31:0] seed, input int lat0);
    logic [4:0]  a;
    logic [31:0] m, d;
    exp_t        e;
    int          nb;
    bit          ok;
    a  = a0;
    nb = (stop < n) ? stop : n;
    m  = {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      d   = seed + i;
      cyc = 1; stb = 1; we = wr; adr = a; sel = sl; dat = d; bte = bt;
      cti = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      e.rd = !wr; e.last = (cti != 3'b010); e.a = a;
      if (wr) begin
        rmem[a] = (rmem[a] & ~m) | (d & m);
        e.d = d;
      end else e.d = rmem[a];
      sbq.push_back(e);
      wait_ack((i == 0) ? lat0 : 1, ok);
      if (!ok) break;
      @(posedge clk); #1;
      a = nxt(a, bt);
    end
    stb = 0; cti = 3'b000;
    if (nb < n) begin
      @(negedge clk);
      total++;
      if (ack_o !== 1'b0 || mem_we_o !== 2'b00) begin
        bad++;
        $display("FAIL stb_drop got ack=%b we=%b exp ack=0 we=00", ack_o, mem_we_o);
      end
    end
    cyc = 0; we = 0;
  endtask

  task automatic rd(input logic [4:0] a);
    xfer(0, a, 2'b00, 1, 1, 4'hF, 32'h0, 2);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    bit ok;
    exp_t e;
    rst_i = 1; cyc = 0; stb = 0; we = 0; adr = '0; sel = 4'hF; dat = '0; cti = '0; bte = '0;
    #3;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_oe", 64'(mem_oe_o), 64'd0);
    chk("rst_dat_bank0", 64'(dat_o), 64'h1111_1111);
    chk("rm_code", 64'(mem_rm_o), 64'h8);
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    #1 chk("me_on", 64'(mem_me_o), 64'h3);

    // Masked classic write then read: word 5 becomes 0x10ADBE05.
    xfer(1, 5'd5, 2'b00, 1, 1, 4'b0110, 32'hDEAD_BEEF, 2);
    rd(5'd5);
    chk("masked_merge_model", 64'(rmem[5]), 64'h10AD_BE05);

    // Linear read burst crossing from bank 0 row 15 into bank 1.
    xfer(0, 5'd15, 2'b00, 8, 8, 4'hF, 32'h0, 2);

    // Wrap-4 write at word 6 lands on 6,7,4,5.
    xfer(1, 5'd6, 2'b01, 4, 4, 4'hF, 32'hC0DE_0000, 2);
    chk("wrap4_word4_model", 64'(rmem[4]), 64'hC0DE_0002);
    for (int w = 4; w < 8; w++) rd(5'(w));

    // Wrap-8 read at word 21: 21,22,23,16..20.
    xfer(0, 5'd21, 2'b10, 8, 8, 4'hF, 32'h0, 2);

    // Write burst of 4 abandoned after 2 beats.
    xfer(1, 5'd24, 2'b00, 4, 2, 4'hF, 32'hA5A5_0000, 2);
    xfer(0, 5'd24, 2'b00, 4, 4, 4'hF, 32'h0, 2);

    // Reset mid-burst on the second write beat.
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = 5'd28; sel = 4'hF; dat = 32'hBAD0_0000; cti = 3'b010; bte = 2'b00;
    rmem[28] = 32'hBAD0_0000;
    e.rd = 0; e.last = 0; e.a = 5'd28; e.d = 32'hBAD0_0000;
    sbq.push_back(e);
    wait_ack(2, ok);
    @(posedge clk); #1;
    adr = 5'd29; dat = 32'hBAD0_0001;
    #2 rst_i = 1;
    #1;
    chk("rst_mid_ack", 64'(ack_o), 64'd0);
    chk("rst_mid_we", 64'(mem_we_o), 64'd0);
    cyc = 0; stb = 0; we = 0; cti = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    rd(5'd28);
    rd(5'd29);
    chk("unacked_word_model", 64'(rmem[29]), 64'h2000_000D);

`ifdef SRAM_SLEEP_EN
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1 chk("sleep_me", 64'(mem_me_o), 64'd0);
    xfer(0, 5'd3, 2'b00, 1, 1, 4'hF, 32'h0, 4);
    #1 chk("wake_me", 64'(mem_me_o), 64'h3);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
